// File: rtl/axis_pattern_gen_multi.sv
// AXI4-Stream test-pattern master: paced ticks, selectable pattern (counter, PRBS15,
// walking-one, constant), TLAST packetisation, bounded backlog and overflow counting.
module axis_pattern_gen_multi #(
  parameter int unsigned              TDATA_WIDTH   = 32,
  parameter logic [TDATA_WIDTH-1:0]   COUNTER_START = '0,
  parameter logic [TDATA_WIDTH-1:0]   COUNTER_END   = TDATA_WIDTH'(255),
  parameter logic [TDATA_WIDTH-1:0]   COUNTER_INCR  = TDATA_WIDTH'(1),
  parameter int unsigned              DIVIDER       = 5,
  parameter int unsigned              PACKET_LEN    = 16,
  parameter int unsigned              MAX_BACKLOG   = 4,
  parameter logic [14:0]              PRBS_SEED     = 15'h7FFF,
  parameter logic [31:0]              CONST_PATTERN = 32'hA5A5A5A5
) (
  input  logic                   m_axis_aclk,
  input  logic                   m_axis_areset,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic                   m_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  output logic [15:0]            overflow_count,
  output logic [1:0]             active_mode
);

  localparam int unsigned W      = TDATA_WIDTH;
  localparam int unsigned DIV_W  = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int unsigned BEAT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam int unsigned CRED_W = $clog2(MAX_BACKLOG + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIVIDER - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PACKET_LEN - 1);
  localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(MAX_BACKLOG);

  localparam logic [W-1:0]    SPAN      = W'(COUNTER_END - COUNTER_START + 1);
  localparam logic [W-1:0]    WRAP_AT   = COUNTER_END - COUNTER_INCR;
  localparam logic [W-1:0]    PRBS_INIT = {{(W-15){1'b0}}, PRBS_SEED};
  localparam logic [W+31:0]   CONST_EXT = {{W{1'b0}}, CONST_PATTERN};
  localparam logic [W-1:0]    CONST_W   = CONST_EXT[W-1:0];
  localparam logic [W-1:0]    ONE_W     = W'(1);

  function automatic logic [W-1:0] seed_of(input logic [1:0] m);
    case (m)
      2'd0:    seed_of = COUNTER_START;
      2'd1:    seed_of = PRBS_INIT;
      2'd2:    seed_of = ONE_W;
      default: seed_of = CONST_W;
    endcase
  endfunction

  // Counter wrap keeps the value inside [COUNTER_START, COUNTER_END] for any step size.
  function automatic logic [W-1:0] next_of(input logic [1:0] m, input logic [W-1:0] cur);
    case (m)
      2'd0:    next_of = (cur > WRAP_AT) ? cur + COUNTER_INCR - SPAN : cur + COUNTER_INCR;
      2'd1:    next_of = {{(W-15){1'b0}}, cur[13:0], cur[14] ^ cur[13]};
      2'd2:    next_of = {cur[W-2:0], cur[W-1]};
      default: next_of = CONST_W;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    sat_inc16 = (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  logic [DIV_W-1:0]  divctr;
  logic [CRED_W-1:0] credits;
  logic [BEAT_W-1:0] beat;
  logic              tick;
  logic              hs;

  assign m_axis_tvalid = (credits != '0);
  assign m_axis_tlast  = (beat == BEAT_LAST);

  always_comb begin
    tick = enable && (divctr == DIV_LAST);
    hs   = m_axis_tvalid && m_axis_tready;
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      divctr         <= '0;
      credits        <= '0;
      beat           <= '0;
      overflow_count <= '0;
      active_mode    <= mode;
      m_axis_tdata   <= seed_of(mode);
    end else begin
      if (enable)
        divctr <= tick ? '0 : divctr + 1'b1;

      // A tick arriving with a full backlog and no drain is dropped and counted.
      if (tick && !hs) begin
        if (credits == CRED_MAX)
          overflow_count <= sat_inc16(overflow_count);
        else
          credits <= credits + 1'b1;
      end else if (hs && !tick) begin
        credits <= credits - 1'b1;
      end

      if (hs) begin
        beat <= m_axis_tlast ? '0 : beat + 1'b1;
        if (m_axis_tlast && (mode != active_mode)) begin
          active_mode  <= mode;
          m_axis_tdata <= seed_of(mode);
        end else begin
          m_axis_tdata <= next_of(active_mode, m_axis_tdata);
        end
      end
    end
  end

endmodule
